// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N digit counter chain.
//   dir_e           : count direction encoding (matches the up_dn pin).
//   CLOCK_MODULI    : default MM:SS digit moduli, least significant digit first.
//   digit_terminal  : 1 when a digit sits at the value that makes it roll over
//                     on its next step in the given direction.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int CLOCK_MODULI [4] = '{10, 6, 10, 6};

  function automatic logic digit_terminal(input int unsigned value,
                                          input int unsigned modulus,
                                          input dir_e        dir);
    if (dir == DIR_UP) begin
      return value == (modulus - 1);
    end
    return value == 0;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-MOD digit of the counter chain.
//   clk, reset : rising-edge clock, asynchronous active-low reset.
//   step       : advance this digit one position this cycle.
//   up_dn      : 1 = up, 0 = down.
//   clear      : synchronous clear (beats load and step).
//   load       : synchronous load of load_d, clamped to MOD-1 (beats step).
//   q          : current digit value.
//   term       : combinational terminal flag for the current direction.
//   clamped    : combinational, load_d is out of range (meaningful while load).
module mod_digit
  import counter_pkg::*;
#(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         up_dn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_d,
  output logic [W-1:0] q,
  output logic         term,
  output logic         clamped
);

  localparam logic [W-1:0] MaxVal = W'(MOD - 1);
  localparam logic [W-1:0] One    = W'(1);

  logic [W-1:0] q_d, q_q;
  logic [W-1:0] load_clamped;

  assign clamped      = load_d > MaxVal;
  assign load_clamped = clamped ? MaxVal : load_d;
  assign term         = digit_terminal(32'(q_q), MOD, dir_e'(up_dn));
  assign q            = q_q;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_clamped;
    end else if (step) begin
      if (up_dn) begin
        q_d = (q_q == MaxVal) ? '0 : q_q + One;
      end else begin
        q_d = (q_q == '0) ? MaxVal : q_q - One;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/mod_chain_counter.sv
// Cascade of modulo-N digit counters with up/down count, clamped load, clear
// and a sticky full-chain wrap flag. Digit 0 is least significant.
//   clk, reset   : rising-edge clock, asynchronous active-low reset.
//   c_in         : count enable, one step per cycle.
//   up_dn        : 1 = up, 0 = down.
//   clear        : synchronous clear of digits, wrap_sticky and load_err.
//   load         : synchronous load of load_val (per-digit clamp).
//   load_val / q : digit i at [i*DIGIT_W +: DIGIT_W].
//   carry        : combinational terminal-count (carry up / borrow down).
//   wrap_sticky  : set whenever the whole chain wraps.
//   load_err     : one-cycle pulse after a load that clamped any digit.
module mod_chain_counter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS          = 4,
  parameter int unsigned DIGIT_W             = 4,
  parameter int          MODULI [NUM_DIGITS] = CLOCK_MODULI
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          c_in,
  input  logic                          up_dn,
  input  logic                          clear,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0] q,
  output logic                          carry,
  output logic                          wrap_sticky,
  output logic                          load_err
);

  logic [NUM_DIGITS-1:0] term;
  logic [NUM_DIGITS-1:0] step;
  logic [NUM_DIGITS-1:0] clamped;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (MODULI[i] < 2 || MODULI[i] > (2 ** DIGIT_W)) begin : g_bad_modulus
      $error("mod_chain_counter: MODULI[%0d]=%0d out of range", i, MODULI[i]);
    end

    mod_digit #(
      .MOD (MODULI[i]),
      .W   (DIGIT_W)
    ) u_digit (
      .clk     (clk),
      .reset   (reset),
      .step    (step[i]),
      .up_dn   (up_dn),
      .clear   (clear),
      .load    (load),
      .load_d  (load_val[i*DIGIT_W +: DIGIT_W]),
      .q       (q[i*DIGIT_W +: DIGIT_W]),
      .term    (term[i]),
      .clamped (clamped[i])
    );
  end

  // Ripple enable: a digit steps only when every lower digit is terminal.
  always_comb begin
    step[0] = c_in;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      step[i] = step[i-1] & term[i-1];
    end
  end

  assign carry = c_in & ~clear & ~load & (&term);

  logic wrap_d, wrap_q;
  logic load_err_d, load_err_q;

  always_comb begin
    wrap_d     = wrap_q;
    load_err_d = 1'b0;
    if (clear) begin
      wrap_d = 1'b0;
    end else if (load) begin
      load_err_d = |clamped;
    end else if (carry) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap_sticky = wrap_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_mod_chain_counter.sv
module tb_mod_chain_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_in, up_dn, clear, load;
  logic [15:0] load_val;
  logic [15:0] q;
  logic        carry, wrap_sticky, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected q values, pushed when stimulus is applied, popped after the edge.
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  mod_chain_counter dut (
    .clk         (clk),
    .reset       (reset),
    .c_in        (c_in),
    .up_dn       (up_dn),
    .clear       (clear),
    .load        (load),
    .load_val    (load_val),
    .q           (q),
    .carry       (carry),
    .wrap_sticky (wrap_sticky),
    .load_err    (load_err)
  );

  // Reference next-state for the MM:SS chain; also returns the chain carry.
  function automatic logic [15:0] ref_next(input logic [15:0] v, input logic up,
                                           output logic cy);
    int          m [4] = '{10, 6, 10, 6};
    logic [15:0] r     = v;
    logic        go    = 1'b1;
    int          d, nd;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[i*4 +: 4]);
      if (go) begin
        if (up) nd = (d == m[i] - 1) ? 0 : d + 1;
        else    nd = (d == 0) ? m[i] - 1 : d - 1;
        r[i*4 +: 4] = 4'(nd);
        go = up ? (d == m[i] - 1) : (d == 0);
      end
    end
    cy = go;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_in = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 16'h0000;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if (q !== 16'h0000) begin
      n_fail++; $display("FAIL reset_q: got %h expected %h", q, 16'h0000);
    end
    reset = 1'b1;
    tick();
    load = 1'b1; load_val = 16'h0342; exp_q.push_back(16'h0342);
    tick();
    load = 1'b0; c_in = 1'b1;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e) begin
      n_fail++; $display("FAIL reset_preload: got %h expected %h", q, e);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (q !== 16'h0000 || wrap_sticky !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got q=%h wrap=%b lerr=%b expected 0000/0/0",
               q, wrap_sticky, load_err);
    end
    c_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_count_up();
    logic [15:0] e;
    idle_inputs();
    load = 1'b1; load_val = 16'h0959; exp_q.push_back(16'h0959);
    tick();
    load = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || load_err !== 1'b0) begin
      n_fail++; $display("FAIL up_load: got %h/%b expected %h/0", q, load_err, e);
    end
    c_in = 1'b1; up_dn = 1'b1; exp_q.push_back(16'h1000);
    #1;
    n_checks++;
    if (carry !== 1'b0) begin
      n_fail++; $display("FAIL up_carry: got %b expected 0", carry);
    end
    tick();
    c_in = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || carry !== 1'b0) begin
      n_fail++; $display("FAIL up_step: got %h carry=%b expected %h carry=0", q, carry, e);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    idle_inputs();
    load = 1'b1; load_val = 16'h5959; exp_q.push_back(16'h5959);
    tick();
    load = 1'b0;
    e = exp_q.pop_front();
    c_in = 1'b1; up_dn = 1'b1; exp_q.push_back(16'h0000);
    #1;
    n_checks++;
    if (carry !== 1'b1 || wrap_sticky !== 1'b0) begin
      n_fail++; $display("FAIL wrap_carry: got carry=%b wrap=%b expected 1/0", carry, wrap_sticky);
    end
    tick();
    c_in = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || wrap_sticky !== 1'b1) begin
      n_fail++; $display("FAIL wrap_q: got %h wrap=%b expected %h/1", q, wrap_sticky, e);
    end
    load = 1'b1; load_val = 16'h0101;
    tick(); load = 1'b0; tick(); tick();
    n_checks++;
    if (wrap_sticky !== 1'b1) begin
      n_fail++; $display("FAIL wrap_hold: got %b expected 1", wrap_sticky);
    end
    clear = 1'b1; exp_q.push_back(16'h0000);
    tick();
    clear = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || wrap_sticky !== 1'b0) begin
      n_fail++; $display("FAIL wrap_clear: got %h wrap=%b expected %h/0", q, wrap_sticky, e);
    end
  endtask

  task automatic test_count_down();
    logic [15:0] e;
    idle_inputs();
    load = 1'b1; load_val = 16'h1000;
    tick();
    load = 1'b0;
    c_in = 1'b1; up_dn = 1'b0; exp_q.push_back(16'h0959);
    #1;
    n_checks++;
    if (carry !== 1'b0) begin
      n_fail++; $display("FAIL down_carry0: got %b expected 0", carry);
    end
    tick();
    c_in = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e) begin
      n_fail++; $display("FAIL down_step: got %h expected %h", q, e);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    c_in = 1'b1; up_dn = 1'b0; exp_q.push_back(16'h5959);
    #1;
    n_checks++;
    if (carry !== 1'b1) begin
      n_fail++; $display("FAIL down_borrow: got %b expected 1", carry);
    end
    tick();
    c_in = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || wrap_sticky !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap: got %h wrap=%b expected %h/1", q, wrap_sticky, e);
    end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_clamp();
    logic [15:0] e;
    idle_inputs();
    load = 1'b1; load_val = 16'h7A80; exp_q.push_back(16'h5950);
    tick();
    load = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || load_err !== 1'b1) begin
      n_fail++; $display("FAIL clamp_load: got %h lerr=%b expected %h/1", q, load_err, e);
    end
    tick();
    n_checks++;
    if (load_err !== 1'b0) begin
      n_fail++; $display("FAIL clamp_pulse: got %b expected 0", load_err);
    end
    load = 1'b1; load_val = 16'h1234; exp_q.push_back(16'h1234);
    tick();
    load = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || load_err !== 1'b0) begin
      n_fail++; $display("FAIL clamp_clean: got %h lerr=%b expected %h/0", q, load_err, e);
    end
    // Modulus-16 case is impossible here, so check the top digit boundary exactly.
    load = 1'b1; load_val = 16'h6000; exp_q.push_back(16'h5000);
    tick();
    load = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || load_err !== 1'b1) begin
      n_fail++; $display("FAIL clamp_edge: got %h lerr=%b expected %h/1", q, load_err, e);
    end
  endtask

  task automatic test_priority();
    logic [15:0] e;
    idle_inputs();
    load = 1'b1; load_val = 16'h5959;
    tick();
    clear = 1'b1; load = 1'b1; load_val = 16'h5959; c_in = 1'b1; up_dn = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    n_checks++;
    if (carry !== 1'b0) begin
      n_fail++; $display("FAIL prio_carry: got %b expected 0", carry);
    end
    tick();
    clear = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e || wrap_sticky !== 1'b0) begin
      n_fail++; $display("FAIL prio_clear: got %h wrap=%b expected %h/0", q, wrap_sticky, e);
    end
    load = 1'b1; load_val = 16'h0123; c_in = 1'b1; exp_q.push_back(16'h0123);
    tick();
    load = 1'b0; c_in = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (q !== e) begin
      n_fail++; $display("FAIL prio_load: got %h expected %h", q, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e, model;
    logic        cy, wrap_m;
    idle_inputs();
    clear = 1'b1; tick(); clear = 1'b0;
    load = 1'b1; load_val = 16'h5955; model = 16'h5955;
    tick();
    load = 1'b0;
    wrap_m = 1'b0;
    for (int n = 0; n < 60; n++) begin
      c_in  = ($urandom_range(0, 3) != 0);
      up_dn = (n < 30) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      if (c_in) model = ref_next(model, up_dn, cy);
      else cy = 1'b0;
      exp_q.push_back(model);
      #1;
      n_checks++;
      if (carry !== cy) begin
        n_fail++; $display("FAIL b2b_carry[%0d]: got %b expected %b", n, carry, cy);
      end
      wrap_m = wrap_m | cy;
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (q !== e) begin
        n_fail++; $display("FAIL b2b_q[%0d]: got %h expected %h", n, q, e);
      end
    end
    c_in = 1'b0;
    n_checks++;
    if (wrap_sticky !== wrap_m) begin
      n_fail++; $display("FAIL b2b_wrap: got %b expected %b", wrap_sticky, wrap_m);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_count_down();
    test_clamp();
    test_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_chain_counter.md
Name: mod_chain_counter

Overview:
- Parametrised cascade of modulo-N digit counters, the generalised successor to the single fixed mod-6 clock digit.
- Digit count and per-digit modulus are parameters; adds up/down counting, synchronous load with range clamping, synchronous clear, and a sticky wrap flag.
- Default configuration is an MM:SS time counter (digits mod 10, 6, 10, 6) used by the clock/timer datapath.
- Digit 0 is least significant; carry ripples combinationally within one clock.

Parameters:
- NUM_DIGITS, 4, number of cascaded digits (1..8).
- DIGIT_W, 4, bits per digit; elaboration error if any modulus exceeds 2**DIGIT_W.
- MODULI, '{10,6,10,6}, unpacked int array [NUM_DIGITS]; MODULI[i] is the modulus of digit i, range 2..2**DIGIT_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- c_in  input  1  count enable: one step per cycle while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled with c_in.
- clear  input  1  synchronous clear of all digits.
- load  input  1  synchronous parallel load.
- load_val  input  NUM_DIGITS*DIGIT_W  load data; digit i is at [i*DIGIT_W +: DIGIT_W].
- q  output  NUM_DIGITS*DIGIT_W  current digit values, same packing as load_val.
- carry  output  1  combinational terminal-count pulse (carry when up, borrow when down).
- wrap_sticky  output  1  set on a full-chain wrap; cleared by clear or reset.
- load_err  output  1  registered one-cycle pulse: the previous load clamped at least one digit.

Behaviour:
- Reset (reset==0, asynchronous, overrides everything): q=0, wrap_sticky=0, load_err=0. Counting resumes on the first rising edge after deassertion.
- Per-cycle priority at the rising edge: clear > load > count > hold.
- clear: q<=0, wrap_sticky<=0, load_err<=0.
- load, without clear:
  - Digit i <= min(load_val digit i, MODULI[i]-1).
  - load_err <= 1 if any digit was clamped, else 0.
  - wrap_sticky is unchanged.
- Count (c_in=1, no clear, no load):
  - Digit 0 always steps.
  - Digit i>0 steps only when every lower digit is at its terminal value: MODULI[j]-1 when up, 0 when down.
  - Up step: value==MODULI[i]-1 -> 0, else +1.
  - Down step: value==0 -> MODULI[i]-1, else -1.
- Latency: q reflects a count, load or clear one clock after the sampling edge.
- carry = c_in & ~clear & ~load & (all digits terminal for the current up_dn). It is combinational and is asserted in the same cycle as the edge that wraps the chain.
- wrap_sticky <= 1 on any edge where carry==1. It holds until clear or reset.
- load_err is 0 in every cycle that did not follow a load edge.
- up_dn may change every cycle; there is no turnaround penalty.
- If the current q holds out-of-range digits (only possible if MODULI changes, which is illegal), behaviour is undefined. Loads always produce in-range values.
- NUM_DIGITS=1 is legal: carry depends only on digit 0.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_e.
  - Constant CLOCK_MODULI = '{10,6,10,6}.
  - Function digit_terminal(value, modulus, dir) returning logic.
- Sub-module mod_digit, instantiated via a generate loop:
  - Parameters MOD, W.
  - Ports: clk, reset, step, up_dn, clear, load, load_d, q, term.
  - term is the combinational terminal flag.
  - Clamping is done inside the digit, which also returns a clamped flag.
- Chain logic: step[i] = c_in & AND(term[0..i-1]). Carry, wrap_sticky and the load_err register live in the top level.

Test Plan:
- Assert reset mid-count while q=16'h0342 and c_in=1 -> q=16'h0000 immediately, without waiting for clk; wrap_sticky=0 and load_err=0.
- Load 16'h0959, then c_in=1 with up_dn=1 for one cycle -> q=16'h1000 and carry=0 throughout.
- Load 16'h5959, then c_in=1 with up_dn=1 -> carry=1 in that cycle; next cycle q=16'h0000 and wrap_sticky=1, held until clear.
- Load 16'h1000, c_in=1 with up_dn=0 -> q=16'h0959. Then clear, then count down one step from 16'h0000 -> carry=1 and q=16'h5959.
- Load 16'h7A80 -> q=16'h5950 (digit 3 clamped to 5, digit 2 clamped to 9, digit 1 clamped to 5) and load_err=1 for exactly one cycle. Load 16'h1234 -> load_err=0.
- Assert clear, load (16'h5959) and c_in together while q=16'h5959 -> carry=0 and next q=16'h0000. Then load with c_in -> the load wins and no step occurs.
